// File: rtl/hazard_control.sv
// hazard_control: stall/flush/freeze sequencing and registered EX operand-forwarding selects for the 5-stage core.
// Optional feature macro: HAZARD_FORWARD_EN (forwarding registers present, only loads stall).
module hazard_control #(
    parameter int LOAD_STALL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_we,
    output logic        idex_bubble,
    output logic        exmem_we,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] LOAD_N = 2'(LOAD_STALL);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [5:0] opcode;
    logic [4:0] rs, rt;
    logic       rs_used, rt_used;
    logic       rs_ex, rt_ex, rs_mem, rt_mem;
    logic       ex_match, mem_match;
    logic [1:0] need_n;

    assign opcode = id_instr[31:26];
    assign rs     = id_instr[25:21];
    assign rt     = id_instr[20:16];

    // Register 0 is hard-wired, so it can never be a real dependency.
    assign rs_used = id_valid && (rs != 5'd0) &&
                     !(opcode == OP_J || opcode == OP_JAL || opcode == OP_LUI);
    assign rt_used = id_valid && (rt != 5'd0) &&
                     (opcode == OP_RTYPE || opcode == OP_SW ||
                      opcode == OP_BEQ   || opcode == OP_BNE);

    assign rs_ex  = rs_used && ex_reg_write  && (rs == ex_rd);
    assign rt_ex  = rt_used && ex_reg_write  && (rt == ex_rd);
    assign rs_mem = rs_used && mem_reg_write && (rs == mem_rd);
    assign rt_mem = rt_used && mem_reg_write && (rt == mem_rd);

    assign ex_match  = rs_ex  || rt_ex;
    assign mem_match = rs_mem || rt_mem;

    always_comb begin
        need_n = 2'd0;
`ifdef HAZARD_FORWARD_EN
        if (ex_match && ex_mem_read) begin
            need_n = LOAD_N;
        end
`else
        if (ex_match) begin
            need_n = 2'd2;
        end else if (mem_match) begin
            need_n = 2'd1;
        end
`endif
    end

    logic unused_ok;
    assign unused_ok = ^{id_instr[15:0], ex_mem_read, mem_match, LOAD_N};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A freeze holds everything; a taken branch cancels any stall in progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!mem_busy) begin
            if (branch_taken) begin
                state_d = S_RUN;
                cnt_d   = 2'd0;
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (need_n > 2'd1) begin
                            state_d = S_STALL;
                            cnt_d   = need_n - 2'd1;
                        end
                    end
                    S_STALL: begin
                        if (cnt_q <= 2'd1) begin
                            state_d = S_RUN;
                            cnt_d   = 2'd0;
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                    default: begin
                        state_d = S_RUN;
                        cnt_d   = 2'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;
        stall       = 1'b0;
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == S_STALL || need_n != 2'd0) begin
            stall       = 1'b1;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_FORWARD_EN
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    // EX is the younger producer, so it wins over MEM.
    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (idex_we) begin
            if (idex_bubble) begin
                fwd_a_d = FWD_RF;
                fwd_b_d = FWD_RF;
            end else begin
                fwd_a_d = rs_ex ? FWD_EXMEM : (rs_mem ? FWD_MEMWB : FWD_RF);
                fwd_b_d = rt_ex ? FWD_EXMEM : (rt_mem ? FWD_MEMWB : FWD_RF);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios then random traffic against a
// remaining-stall-cycles reference model. Honours HAZARD_FORWARD_EN like the design.
module tb_hazard_control;

    localparam int LS = 1;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        branch_taken;
    logic        mem_busy;
    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, stall;
    logic [1:0]  fwd_a, fwd_b;

    always #5 clk = ~clk;

    hazard_control #(.LOAD_STALL(LS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_we      (idex_we),
        .idex_bubble  (idex_bubble),
        .exmem_we     (exmem_we),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pc_low = 0;

    // Model state: stall cycles still owed after this one, and forwarding selects now in EX.
    int         rem_m = 0;
    logic [1:0] fa_m  = 2'b00;
    logic [1:0] fb_m  = 2'b00;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0000};
    endfunction

    function automatic bit src_used(input int which);
        int op;
        op = int'(id_instr[31:26]);
        if (!id_valid) return 1'b0;
        if (which == 0)
            return (id_instr[25:21] != 5'd0) && !(op == 2 || op == 3 || op == 15);
        return (id_instr[20:16] != 5'd0) && (op == 0 || op == 43 || op == 4 || op == 5);
    endfunction

    function automatic logic [4:0] src_reg(input int which);
        return (which == 0) ? id_instr[25:21] : id_instr[20:16];
    endfunction

    function automatic int need_of();
        int n = 0;
        int c;
        for (int s = 0; s < 2; s++) begin
            if (src_used(s)) begin
                if (ex_reg_write && src_reg(s) == ex_rd) begin
                    c = FWD ? (ex_mem_read ? LS : 0) : 2;
                    if (c > n) n = c;
                end
                if (mem_reg_write && src_reg(s) == mem_rd) begin
                    c = FWD ? 0 : 1;
                    if (c > n) n = c;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [1:0] sel_of(input int s);
        if (!FWD || !src_used(s)) return 2'b00;
        if (ex_reg_write && src_reg(s) == ex_rd) return 2'b01;
        if (mem_reg_write && src_reg(s) == mem_rd) return 2'b10;
        return 2'b00;
    endfunction

    // One clock: check outputs at the falling edge, advance the model past the rising edge.
    task automatic do_cycle(input string tag);
        logic [6:0] exp_c, obs_c;
        logic [1:0] fa_n, fb_n;
        int         rem_n, n;
        @(negedge clk);
        cyc++;
        fa_n  = fa_m;
        fb_n  = fb_m;
        rem_n = rem_m;
        if (!rst_n) begin
            exp_c = 7'b0010100;
            rem_n = 0; fa_n = 2'b00; fb_n = 2'b00;
        end else if (mem_busy) begin
            exp_c = 7'b0000000;
        end else if (branch_taken) begin
            exp_c = 7'b1111110;
            rem_n = 0; fa_n = 2'b00; fb_n = 2'b00;
        end else if (rem_m > 0) begin
            exp_c = 7'b0001111;
            rem_n = rem_m - 1; fa_n = 2'b00; fb_n = 2'b00;
        end else begin
            n = need_of();
            if (n > 0) begin
                exp_c = 7'b0001111;
                rem_n = n - 1; fa_n = 2'b00; fb_n = 2'b00;
            end else begin
                exp_c = 7'b1101010;
                fa_n = sel_of(0); fb_n = sel_of(1);
            end
        end
        obs_c = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we,
                 (rst_n && mem_busy) ? 1'b0 : stall};
        if (pc_we === 1'b0) pc_low++;
        $display("[TB] %s cyc=%0d ctl=%b fwd_a=%b fwd_b=%b", tag, cyc, obs_c, fwd_a, fwd_b);
        chk({tag, "/ctl"}, {1'b0, obs_c}, {1'b0, exp_c});
        chk({tag, "/fwd_a"}, {6'd0, fwd_a}, {6'd0, fa_m});
        chk({tag, "/fwd_b"}, {6'd0, fwd_b}, {6'd0, fb_m});
        @(posedge clk);
        #1;
        rem_m = rem_n;
        fa_m  = fa_n;
        fb_m  = fb_n;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_instr = 32'h0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    logic [5:0] ops [8] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd15, 6'd35, 6'd43};

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;

        do_cycle("reset");
        rst_n = 1'b1;
        do_cycle("idle");

        // Load-use: load r5 in EX, ADD r?,r5,r6 in decode.
        id_valid = 1'b1; id_instr = mk(0, 5, 6);
        ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        do_cycle("ldu1");
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_rd = 5'd5; mem_reg_write = 1'b1;
        do_cycle("ldu2");
        idle_inputs();
        do_cycle("ldu3");
        do_cycle("ldu4");

        // RAW from EX: ADD writes r3, SW uses rt=3.
        pc_low = 0;
        id_valid = 1'b1; id_instr = mk(43, 1, 3);
        ex_rd = 5'd3; ex_reg_write = 1'b1;
        do_cycle("raw1");
        ex_reg_write = 1'b0; mem_rd = 5'd3; mem_reg_write = 1'b1;
        do_cycle("raw2");
        mem_reg_write = 1'b0;
        do_cycle("raw3");
`ifndef HAZARD_FORWARD_EN
        chk("raw/stall_cycles", 8'(pc_low), 8'd2);
`endif
        idle_inputs();
        do_cycle("raw4");

        // Branch taken in the middle of a stall.
        id_valid = 1'b1; id_instr = mk(0, 3, 0);
        ex_rd = 5'd3; ex_reg_write = 1'b1;
        do_cycle("br1");
        ex_reg_write = 1'b0; mem_rd = 5'd3; mem_reg_write = 1'b1; branch_taken = 1'b1;
        do_cycle("br2");
        idle_inputs();
        do_cycle("br3");

        // Freeze for 3 cycles inside a stall.
        pc_low = 0;
        id_valid = 1'b1; id_instr = mk(43, 1, 3);
        ex_rd = 5'd3; ex_reg_write = 1'b1;
        do_cycle("frz1");
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle("frz_busy");
        mem_busy = 1'b0; ex_reg_write = 1'b0; mem_rd = 5'd3; mem_reg_write = 1'b1;
        do_cycle("frz5");
        mem_reg_write = 1'b0;
        do_cycle("frz6");
`ifndef HAZARD_FORWARD_EN
        chk("frz/pc_low_cycles", 8'(pc_low), 8'd5);
`endif
        idle_inputs();

        // False hazards: r0 destination, J field aliasing, invalid decode slot.
        id_valid = 1'b1; id_instr = mk(0, 0, 0); ex_rd = 5'd0; ex_reg_write = 1'b1;
        do_cycle("fh_r0");
        id_instr = mk(2, 7, 0); ex_rd = 5'd7;
        do_cycle("fh_j");
        id_instr = mk(0, 7, 7); id_valid = 1'b0; mem_rd = 5'd7; mem_reg_write = 1'b1;
        do_cycle("fh_inv");
        idle_inputs();
        do_cycle("fh_end");

        // Reset asserted during a stall.
        id_valid = 1'b1; id_instr = mk(0, 4, 0);
        ex_rd = 5'd4; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        do_cycle("rst1");
        rst_n = 1'b0;
        do_cycle("rst2");
        rst_n = 1'b1; idle_inputs();
        do_cycle("rst3");
        do_cycle("rst4");

        // Random traffic on a small register set so matches are frequent.
        for (int i = 0; i < 500; i++) begin
            rst_n         = ($urandom_range(0, 49) != 0);
            mem_busy      = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            id_valid      = ($urandom_range(0, 4) != 0);
            id_instr      = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                             5'($urandom_range(0, 3)), 16'($urandom)};
            ex_rd         = 5'($urandom_range(0, 3));
            ex_reg_write  = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            mem_rd        = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom_range(0, 1));
            do_cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
